// File: rtl/intersection_scheduler.sv
// rtl/intersection_scheduler.sv - vehicle-actuated two-road intersection scheduler
//
// Moore FSM sharing the crossing between NS traffic, EW traffic and pedestrians.
// Optional feature macro: EMERGENCY_PREEMPT_EN (adds emerg_req / emerg_dir).
//
// Ports:
//   clk                           clock, rising edge
//   rst_n                         asynchronous active-low reset
//   ns_car, ew_car                vehicle sensors (level)
//   ped_req                       pedestrian button (any width pulse)
//   emerg_req, emerg_dir          emergency request / direction (0=NS, 1=EW), macro only
//   ns_red/ns_yellow/ns_green     NS lamps
//   ew_red/ew_yellow/ew_green     EW lamps
//   walk                          pedestrian walk lamp
//   phase                         current state encoding (debug)

module intersection_scheduler #(
  parameter int GREEN_MIN   = 4,
  parameter int GREEN_MAX   = 8,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1,
  parameter int WALK_TIME   = 3,
  parameter int TW          = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ns_car,
  input  logic       ew_car,
  input  logic       ped_req,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic       emerg_req,
  input  logic       emerg_dir,
`endif
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       walk,
  output logic [2:0] phase
);

  localparam logic [2:0] S_ALL_RED   = 3'd0;
  localparam logic [2:0] S_NS_GREEN  = 3'd1;
  localparam logic [2:0] S_NS_YELLOW = 3'd2;
  localparam logic [2:0] S_EW_GREEN  = 3'd3;
  localparam logic [2:0] S_EW_YELLOW = 3'd4;
  localparam logic [2:0] S_WALK      = 3'd5;

  localparam logic [TW-1:0] T_GMIN = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] T_GMAX = TW'(GREEN_MAX - 1);
  localparam logic [TW-1:0] T_YEL  = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] T_AR   = TW'(ALLRED_TIME - 1);
  localparam logic [TW-1:0] T_WALK = TW'(WALK_TIME - 1);
  localparam logic [TW-1:0] T_SAT  = {TW{1'b1}};

  // last_dir: 0 = NS was served last, 1 = EW was served last
  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          last_dir_q, last_dir_d;
  logic          ns_call_q, ns_call_d;
  logic          ew_call_q, ew_call_d;
  logic          ped_pending_q, ped_pending_d;

  // Emergency request for a direction whose green is not yet shown
  logic emerg_ns, emerg_ew;
`ifdef EMERGENCY_PREEMPT_EN
  assign emerg_ns = emerg_req & ~emerg_dir;
  assign emerg_ew = emerg_req &  emerg_dir;
`else
  assign emerg_ns = 1'b0;
  assign emerg_ew = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_ALL_RED;
      timer_q       <= '0;
      last_dir_q    <= 1'b1;
      ns_call_q     <= 1'b0;
      ew_call_q     <= 1'b0;
      ped_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      last_dir_q    <= last_dir_d;
      ns_call_q     <= ns_call_d;
      ew_call_q     <= ew_call_d;
      ped_pending_q <= ped_pending_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    case (state_q)
      S_NS_GREEN: begin
        if (emerg_ew) begin
          state_d = S_NS_YELLOW;
        end else if (!emerg_ns && (ew_call_q || ped_pending_q) &&
                     ((timer_q >= T_GMIN && !ns_car) || timer_q >= T_GMAX)) begin
          state_d = S_NS_YELLOW;
        end
      end
      S_EW_GREEN: begin
        if (emerg_ns) begin
          state_d = S_EW_YELLOW;
        end else if (!emerg_ew && (ns_call_q || ped_pending_q) &&
                     ((timer_q >= T_GMIN && !ew_car) || timer_q >= T_GMAX)) begin
          state_d = S_EW_YELLOW;
        end
      end
      S_NS_YELLOW: begin
        if (timer_q >= T_YEL) begin
          state_d    = S_ALL_RED;
          last_dir_d = 1'b0;
        end
      end
      S_EW_YELLOW: begin
        if (timer_q >= T_YEL) begin
          state_d    = S_ALL_RED;
          last_dir_d = 1'b1;
        end
      end
      S_ALL_RED: begin
        if (timer_q >= T_AR) begin
          if (emerg_ns)           state_d = S_NS_GREEN;
          else if (emerg_ew)      state_d = S_EW_GREEN;
          else if (ped_pending_q) state_d = S_WALK;
          else                    state_d = last_dir_q ? S_NS_GREEN : S_EW_GREEN;
        end
      end
      S_WALK: begin
        if (emerg_ns || emerg_ew)  state_d = S_ALL_RED;
        else if (timer_q >= T_WALK) state_d = last_dir_q ? S_NS_GREEN : S_EW_GREEN;
      end
      default: state_d = S_ALL_RED;
    endcase

    // Timer restarts on every state change and saturates otherwise
    if (state_d != state_q)   timer_d = '0;
    else if (timer_q == T_SAT) timer_d = timer_q;
    else                       timer_d = timer_q + 1'b1;

    // Sticky calls; a clear on entry beats a same-cycle set
    if (state_d == S_NS_GREEN && state_q != S_NS_GREEN) ns_call_d = 1'b0;
    else ns_call_d = ns_call_q | (ns_car & (state_q != S_NS_GREEN));

    if (state_d == S_EW_GREEN && state_q != S_EW_GREEN) ew_call_d = 1'b0;
    else ew_call_d = ew_call_q | (ew_car & (state_q != S_EW_GREEN));

    // WALK only ever leaves to ALL_RED when aborted by an emergency,
    // in which case the pedestrians are still owed their walk
    if (state_d == S_WALK && state_q != S_WALK)        ped_pending_d = 1'b0;
    else if (state_q == S_WALK && state_d == S_ALL_RED) ped_pending_d = 1'b1;
    else ped_pending_d = ped_pending_q | (ped_req & (state_q != S_WALK));
  end

  // Output decode (state register only)
  always_comb begin
    ns_red    = 1'b0;
    ns_yellow = 1'b0;
    ns_green  = 1'b0;
    ew_red    = 1'b0;
    ew_yellow = 1'b0;
    ew_green  = 1'b0;
    walk      = 1'b0;
    phase     = state_q;
    case (state_q)
      S_NS_GREEN:  begin ns_green  = 1'b1; ew_red    = 1'b1; end
      S_NS_YELLOW: begin ns_yellow = 1'b1; ew_red    = 1'b1; end
      S_EW_GREEN:  begin ns_red    = 1'b1; ew_green  = 1'b1; end
      S_EW_YELLOW: begin ns_red    = 1'b1; ew_yellow = 1'b1; end
      S_WALK:      begin ns_red    = 1'b1; ew_red    = 1'b1; walk = 1'b1; end
      default:     begin ns_red    = 1'b1; ew_red    = 1'b1; end
    endcase
  end

endmodule

// File: tb/tb_intersection_scheduler.sv
// tb/tb_intersection_scheduler.sv - directed table-driven bench for intersection_scheduler

module tb_intersection_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ns_car = 1'b0;
  logic       ew_car = 1'b0;
  logic       ped_req = 1'b0;
`ifdef EMERGENCY_PREEMPT_EN
  logic       emerg_req = 1'b0;
  logic       emerg_dir = 1'b0;
`endif
  logic       ns_red, ns_yellow, ns_green;
  logic       ew_red, ew_yellow, ew_green;
  logic       walk;
  logic [2:0] phase;

  always #5 clk = ~clk;

  intersection_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ns_car    (ns_car),
    .ew_car    (ew_car),
    .ped_req   (ped_req),
`ifdef EMERGENCY_PREEMPT_EN
    .emerg_req (emerg_req),
    .emerg_dir (emerg_dir),
`endif
    .ns_red    (ns_red),
    .ns_yellow (ns_yellow),
    .ns_green  (ns_green),
    .ew_red    (ew_red),
    .ew_yellow (ew_yellow),
    .ew_green  (ew_green),
    .walk      (walk),
    .phase     (phase)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       ns;
    logic       ew;
    logic       ped;
    logic       em;
    logic       ed;
    int         reps;
    logic [2:0] ph;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic ns, logic ew, logic ped, logic em, logic ed,
                              int reps, logic [2:0] ph);
    vec_t v;
    v.ns = ns; v.ew = ew; v.ped = ped; v.em = em; v.ed = ed; v.reps = reps; v.ph = ph;
    return v;
  endfunction

  // Expected lamps {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk} per phase
  function automatic logic [6:0] lamps_for(logic [2:0] ph);
    case (ph)
      3'd1:    return 7'b001_100_0;
      3'd2:    return 7'b010_100_0;
      3'd3:    return 7'b100_001_0;
      3'd4:    return 7'b100_010_0;
      3'd5:    return 7'b100_100_1;
      default: return 7'b100_100_0;
    endcase
  endfunction

  task automatic check(string name, logic [2:0] ph);
    logic [9:0] act, exp_v;
    act   = {phase, ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk};
    exp_v = {ph, lamps_for(ph)};
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got phase=%0d lamps=%b, expected phase=%0d lamps=%b",
               name, act[9:7], act[6:0], exp_v[9:7], exp_v[6:0]);
    end
  endtask

  task automatic run_vecs(string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      ns_car  = vecs[i].ns;
      ew_car  = vecs[i].ew;
      ped_req = vecs[i].ped;
`ifdef EMERGENCY_PREEMPT_EN
      emerg_req = vecs[i].em;
      emerg_dir = vecs[i].ed;
`endif
      for (int r = 0; r < vecs[i].reps; r++) begin
        @(posedge clk);
        #1;
        check($sformatf("%s[%0d].%0d", tag, i, r), vecs[i].ph);
      end
    end
    vecs.delete();
  endtask

  initial begin
    // Reset state
    #12;
    check("reset", 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("after_release", 3'd0);

    // Main sequence: rest, gap-out, pedestrian walk, max-out period, clear-wins
    vecs.push_back(mk(0,0,0,0,0, 1, 3'd1));
    vecs.push_back(mk(0,0,0,0,0,50, 3'd1));
    vecs.push_back(mk(0,1,0,0,0, 1, 3'd1));
    vecs.push_back(mk(0,0,0,0,0, 2, 3'd2));
    vecs.push_back(mk(0,0,0,0,0, 1, 3'd0));
    vecs.push_back(mk(0,0,0,0,0, 2, 3'd3));
    vecs.push_back(mk(0,0,1,0,0, 1, 3'd3));
    vecs.push_back(mk(0,0,0,0,0, 1, 3'd3));
    vecs.push_back(mk(0,0,0,0,0, 2, 3'd4));
    vecs.push_back(mk(0,0,0,0,0, 1, 3'd0));
    vecs.push_back(mk(0,0,0,0,0, 1, 3'd5));
    vecs.push_back(mk(0,0,1,0,0, 1, 3'd5));
    vecs.push_back(mk(0,0,0,0,0, 1, 3'd5));
    vecs.push_back(mk(0,0,0,0,0, 1, 3'd1));
    vecs.push_back(mk(0,0,0,0,0,20, 3'd1));
    vecs.push_back(mk(1,1,0,0,0, 1, 3'd1));
    vecs.push_back(mk(1,1,0,0,0, 2, 3'd2));
    vecs.push_back(mk(1,1,0,0,0, 1, 3'd0));
    vecs.push_back(mk(1,1,0,0,0, 8, 3'd3));
    vecs.push_back(mk(1,1,0,0,0, 2, 3'd4));
    vecs.push_back(mk(1,1,0,0,0, 1, 3'd0));
    vecs.push_back(mk(1,1,0,0,0, 8, 3'd1));
    vecs.push_back(mk(1,1,0,0,0, 2, 3'd2));
    vecs.push_back(mk(1,1,0,0,0, 1, 3'd0));
    vecs.push_back(mk(1,1,0,0,0, 8, 3'd3));
    vecs.push_back(mk(1,1,0,0,0, 2, 3'd4));
    vecs.push_back(mk(1,1,0,0,0, 1, 3'd0));
    vecs.push_back(mk(1,1,0,0,0, 1, 3'd1));
    vecs.push_back(mk(0,1,0,0,0, 3, 3'd1));
    vecs.push_back(mk(0,1,0,0,0, 1, 3'd2));
    vecs.push_back(mk(0,0,0,0,0, 1, 3'd2));
    vecs.push_back(mk(0,0,0,0,0, 1, 3'd0));
    vecs.push_back(mk(0,0,0,0,0, 1, 3'd3));
    vecs.push_back(mk(0,0,0,0,0,12, 3'd3));
    vecs.push_back(mk(1,0,0,0,0, 1, 3'd3));
    vecs.push_back(mk(0,0,0,0,0, 1, 3'd4));
    run_vecs("main");

    // Asynchronous reset in the middle of EW_YELLOW
    ns_car = 1'b0; ew_car = 1'b1; ped_req = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_immediate", 3'd0);
    @(posedge clk);
    #1;
    check("reset_held", 3'd0);
    ew_car = 1'b0; ped_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vecs.push_back(mk(0,0,0,0,0, 1, 3'd1));
    vecs.push_back(mk(0,0,0,0,0,10, 3'd1));
    run_vecs("post_reset");

`ifdef EMERGENCY_PREEMPT_EN
    // Preempt towards EW from a resting NS green
    vecs.push_back(mk(0,0,0,1,1, 1, 3'd2));
    vecs.push_back(mk(0,0,0,1,1, 1, 3'd2));
    vecs.push_back(mk(0,0,0,1,1, 1, 3'd0));
    vecs.push_back(mk(0,0,0,1,1, 1, 3'd3));
    vecs.push_back(mk(1,0,0,1,1,10, 3'd3));
    vecs.push_back(mk(1,0,0,0,0, 1, 3'd4));
    run_vecs("emerg");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
